// File: rtl/led_fade_driver.sv
// led_fade_driver: four-channel PWM LED driver whose brightness ramps linearly toward a strobed on/off pattern
module led_fade_driver #(
  parameter int LEVEL_BITS = 8,
  parameter int FADE_DIV   = 1563
) (
  input  logic       clk_10MHz,
  input  logic       resetn,
  input  logic [3:0] pattern_in,
  input  logic       pattern_valid,
  output logic [3:0] led,
  output logic       busy,
  output logic       fade_done
);
  localparam int PW = FADE_DIV > 0 ? $clog2(FADE_DIV + 1) : 1;
  localparam logic [LEVEL_BITS-1:0] MAX = '1;
  logic [PW-1:0] pre;
  logic [LEVEL_BITS-1:0] pwm_cnt;
  logic [3:0] target, target_nx;
  logic [3:0][LEVEL_BITS-1:0] level, level_nx;
  logic tick, busy_nx;
  assign tick = pre == PW'(FADE_DIV);
  // steps use the old target; busy looks at the target being registered now
  always_comb begin
    target_nx = pattern_valid ? pattern_in : target;
    busy_nx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      level_nx[i] = !tick ? level[i] :
                    target[i] ? (level[i] == MAX ? level[i] : level[i] + 1'b1) :
                                (level[i] == '0 ? level[i] : level[i] - 1'b1);
      busy_nx = busy_nx | (level_nx[i] != (target_nx[i] ? MAX : '0));
    end
  end
  always_ff @(posedge clk_10MHz or negedge resetn)
    if (!resetn) begin
      pre       <= '0;
      pwm_cnt   <= '0;
      target    <= '0;
      level     <= '0;
      led       <= '0;
      busy      <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      pre       <= tick ? '0 : pre + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      target    <= target_nx;
      level     <= level_nx;
      for (int i = 0; i < 4; i++) led[i] <= level[i] == MAX || pwm_cnt < level[i];
      busy      <= busy_nx;
      fade_done <= busy & ~busy_nx;
    end
endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: directed and random checks of led_fade_driver against a cycle-count reference model
module tb_led_fade_driver;
  localparam int LB = 4, FD = 3, MX = 15;
  logic clk_10MHz = 0, resetn = 0, pattern_valid = 0, pv2 = 0;
  logic [3:0] pattern_in = 0, pin2 = 0, led, led2;
  logic busy, fade_done, busy2, done2;
  int tests = 0, fails = 0;
  int n, mlev[4];
  bit [3:0] mtgt, mled;
  bit mbusy, mdone;
  always #5 clk_10MHz = ~clk_10MHz;
  led_fade_driver #(.LEVEL_BITS(LB), .FADE_DIV(FD)) dut (
    .clk_10MHz(clk_10MHz), .resetn(resetn), .pattern_in(pattern_in),
    .pattern_valid(pattern_valid), .led(led), .busy(busy), .fade_done(fade_done));
  led_fade_driver #(.LEVEL_BITS(LB), .FADE_DIV(63)) dut2 (
    .clk_10MHz(clk_10MHz), .resetn(resetn), .pattern_in(pin2),
    .pattern_valid(pv2), .led(led2), .busy(busy2), .fade_done(done2));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    n = 0; mtgt = 0; mled = 0; mbusy = 0; mdone = 0;
    for (int i = 0; i < 4; i++) mlev[i] = 0;
  endtask
  // model: tick and pwm phase come from the edge count since reset
  task automatic step();
    bit nb, tk;
    @(posedge clk_10MHz);
    if (!resetn) mreset();
    else begin
      nb = 0;
      tk = (n % (FD + 1)) == FD;
      for (int i = 0; i < 4; i++) begin
        mled[i] = mlev[i] == MX || (n % 16) < mlev[i];
        if (tk && mtgt[i] && mlev[i] < MX) mlev[i]++;
        else if (tk && !mtgt[i] && mlev[i] > 0) mlev[i]--;
      end
      if (pattern_valid) mtgt = pattern_in;
      for (int i = 0; i < 4; i++) nb |= mlev[i] != (mtgt[i] ? MX : 0);
      mdone = mbusy && !nb;
      mbusy = nb;
      n++;
    end
    @(negedge clk_10MHz);
    chk("led", 32'(led), 32'(mled));
    chk("busy", 32'(busy), 32'(mbusy));
    chk("fade_done", 32'(fade_done), 32'(mdone));
    for (int i = 0; i < 4; i++) chk("level", 32'(dut.level[i]), 32'(mlev[i]));
  endtask
  task automatic send(input logic [3:0] p);
    pattern_in = p; pattern_valid = 1;
    step();
    pattern_valid = 0;
  endtask
  initial begin
    int k, cnt, prev;
    mreset();
    resetn = 0; pattern_valid = 1; pattern_in = 4'hF;
    repeat (5) step();
    resetn = 1; pattern_valid = 0; pattern_in = 0;
    repeat (3) step();
    send(4'hA);
    chk("busy_up", 32'(busy), 1);
    k = 0;
    while (!fade_done && k < 100) begin step(); k++; end
    chk("fade_time", 32'(k >= 56 && k <= 64), 1);
    cnt = 0;
    repeat (20) begin step(); cnt += 32'(fade_done); chk("led_full", 32'(led), 32'hA); end
    chk("one_done", 32'(cnt), 0);
    pin2 = 4'hA; pv2 = 1; step(); pv2 = 0;
    k = 0;
    while ((dut2.level[1] != 15 || busy2) && k < 1200) begin step(); k++; end
    chk("duty_settle", 32'(busy2), 0);
    pin2 = 4'h5; pv2 = 1; step(); pv2 = 0;
    k = 0;
    while (dut2.level[1] != 5 && k < 1200) begin step(); k++; end
    chk("duty_reach5", 32'(dut2.level[1]), 5);
    step();
    cnt = 0;
    repeat (16) begin step(); cnt += 32'(led2[1]); end
    chk("duty5", 32'(cnt), 5);
    send(4'h0);
    k = 0;
    while (!fade_done && k < 100) begin step(); k++; end
    chk("settle0", 32'(k < 100), 1);
    send(4'h1);
    k = 0;
    while (dut.level[0] != 7 && k < 100) begin step(); k++; end
    chk("reach7", 32'(dut.level[0]), 7);
    send(4'h0);
    prev = 7; k = 0;
    while (!fade_done && k < 100) begin
      chk("no_jump", 32'(32'(dut.level[0]) == prev || 32'(dut.level[0]) == prev - 1), 1);
      chk("busy_hold", 32'(busy), 1);
      prev = 32'(dut.level[0]);
      step(); k++;
    end
    chk("ret_end", 32'(dut.level[0]), 0);
    cnt = 0;
    repeat (10) begin step(); cnt += 32'(fade_done); end
    chk("ret_one_done", 32'(cnt), 0);
    while (n % (FD + 1) != FD) step();
    send(4'h1);
    chk("coll_hold", 32'(dut.level[0]), 0);
    repeat (4) step();
    chk("coll_step", 32'(dut.level[0]), 1);
    send(4'hF);
    repeat (20) step();
    chk("busy_pre_rst", 32'(busy), 1);
    #2 resetn = 0;
    #1;
    chk("arst_led", 32'(led), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(fade_done), 0);
    mreset();
    repeat (3) step();
    resetn = 1;
    cnt = 0;
    repeat (12) begin step(); cnt += 32'(fade_done); end
    chk("rst_nodone", 32'(cnt), 0);
    repeat (300) begin
      pattern_valid = $urandom_range(0, 15) == 0;
      pattern_in = 4'($urandom);
      step();
    end
    pattern_valid = 0;
    repeat (80) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
